// File: rtl/posicao_pkg.sv
// Package for posicao: action codes, orientation codes and the movement FSM states.
// Imported by posicao_if, prox_pos and posicao.
package posicao_pkg;

  // Action codes carried on acao; 101-111 are invalid.
  localparam logic [2:0] AcaoParado = 3'b000;
  localparam logic [2:0] AcaoNorte  = 3'b001;
  localparam logic [2:0] AcaoOeste  = 3'b010;
  localparam logic [2:0] AcaoLeste  = 3'b011;
  localparam logic [2:0] AcaoSul    = 3'b100;

  // Orientation codes, same encoding as the move actions.
  localparam logic [2:0] OriNorte = 3'b001;
  localparam logic [2:0] OriOeste = 3'b010;
  localparam logic [2:0] OriLeste = 3'b011;
  localparam logic [2:0] OriSul   = 3'b100;

  typedef enum logic [1:0] {
    StAndando,
    StBatida,
    StChegou
  } estado_e;

  function automatic logic acao_valida(logic [2:0] acao);
    return acao <= AcaoSul;
  endfunction

endpackage

// File: rtl/posicao_if.sv
// Bus between a controller and posicao.
//   acao           : action code (master -> slave)
//   alvo_x, alvo_y : target cell (master -> slave)
//   x, y           : current position (slave -> master)
//   bateu          : edge-refusal pulse (slave -> master)
//   chegou         : arrived level (slave -> master)
//   passos         : executed move count (slave -> master)
//   erro           : invalid-action pulse (slave -> master)
interface posicao_if #(
  parameter int unsigned CW = 3
);
  logic [2:0]    acao;
  logic [CW-1:0] alvo_x;
  logic [CW-1:0] alvo_y;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          bateu;
  logic          chegou;
  logic [7:0]    passos;
  logic          erro;

  modport master (
    output acao, alvo_x, alvo_y,
    input  x, y, bateu, chegou, passos, erro
  );

  modport slave (
    input  acao, alvo_x, alvo_y,
    output x, y, bateu, chegou, passos, erro
  );
endinterface

// File: rtl/prox_pos.sv
// prox_pos: combinational next-cell computation for one move action.
//   x, y        : current cell
//   acao        : action code (non-move codes leave the cell unchanged)
//   nx, ny      : cell after the move
//   fora_limite : move would leave the grid and must be refused
// With POSICAO_TORUS_EN defined, edge moves wrap around and fora_limite stays low.
module prox_pos
  import posicao_pkg::*;
#(
  parameter int unsigned LARG = 8,
  parameter int unsigned ALT  = 8,
  parameter int unsigned CW   = 3
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [2:0]    acao,
  output logic [CW-1:0] nx,
  output logic [CW-1:0] ny,
  output logic          fora_limite
);

  localparam logic [CW-1:0] XMax = CW'(LARG - 1);
  localparam logic [CW-1:0] YMax = CW'(ALT - 1);

  always_comb begin
    nx          = x;
    ny          = y;
    fora_limite = 1'b0;
    case (acao)
      AcaoNorte: begin
        if (y == YMax) begin
`ifdef POSICAO_TORUS_EN
          ny = '0;
`else
          fora_limite = 1'b1;
`endif
        end else begin
          ny = y + CW'(1);
        end
      end
      AcaoSul: begin
        if (y == '0) begin
`ifdef POSICAO_TORUS_EN
          ny = YMax;
`else
          fora_limite = 1'b1;
`endif
        end else begin
          ny = y - CW'(1);
        end
      end
      AcaoLeste: begin
        if (x == XMax) begin
`ifdef POSICAO_TORUS_EN
          nx = '0;
`else
          fora_limite = 1'b1;
`endif
        end else begin
          nx = x + CW'(1);
        end
      end
      AcaoOeste: begin
        if (x == '0) begin
`ifdef POSICAO_TORUS_EN
          nx = XMax;
`else
          fora_limite = 1'b1;
`endif
        end else begin
          nx = x - CW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/posicao.sv
// posicao: position tracker on a LARG x ALT grid driven by edge-detected action pulses.
//   c4    : clock, all state changes on the rising edge
//   reset : synchronous active-high reset
//   bus   : posicao_if slave (acao, alvo_x/y in; x, y, bateu, chegou, passos, erro out)
// Optional macro POSICAO_TORUS_EN: edge moves wrap around instead of being refused.
module posicao
  import posicao_pkg::*;
#(
  parameter int unsigned LARG = 8,
  parameter int unsigned ALT  = 8,
  parameter int unsigned X0   = 0,
  parameter int unsigned Y0   = 0
) (
  input  logic      c4,
  input  logic      reset,
  posicao_if.slave  bus
);

  localparam int unsigned MaxDim = (LARG > ALT) ? LARG : ALT;
  localparam int unsigned CW     = ($clog2(MaxDim) > 1) ? $clog2(MaxDim) : 1;

  estado_e       estado_q, estado_d;
  logic [2:0]    acao_q;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [7:0]    passos_q, passos_d;
  logic          erro_q, erro_d;

  logic [CW-1:0] nx, ny;
  logic          fora_limite;
  logic          req;
  logic          alvo_ok;
  logic          no_alvo;

  prox_pos #(
    .LARG (LARG),
    .ALT  (ALT),
    .CW   (CW)
  ) u_prox_pos (
    .x           (x_q),
    .y           (y_q),
    .acao        (bus.acao),
    .nx          (nx),
    .ny          (ny),
    .fora_limite (fora_limite)
  );

  // A held code produces a single request: only the 000 -> non-000 transition counts.
  assign req = (bus.acao != AcaoParado) && (acao_q == AcaoParado);

  // An off-grid target can never match, even when CW leaves room for it.
  assign alvo_ok = (32'(bus.alvo_x) < LARG) && (32'(bus.alvo_y) < ALT);
  assign no_alvo = alvo_ok && (x_q == bus.alvo_x) && (y_q == bus.alvo_y);

  always_comb begin
    estado_d = estado_q;
    x_d      = x_q;
    y_d      = y_q;
    passos_d = passos_q;
    erro_d   = 1'b0;
    unique case (estado_q)
      StAndando: begin
        // Arrival takes priority over a request seen in the same cycle.
        if (no_alvo) begin
          estado_d = StChegou;
        end else if (req) begin
          if (!acao_valida(bus.acao)) begin
            erro_d = 1'b1;
          end else if (fora_limite) begin
            estado_d = StBatida;
          end else begin
            x_d      = nx;
            y_d      = ny;
            passos_d = (passos_q == 8'hFF) ? passos_q : passos_q + 8'd1;
          end
        end
      end
      StBatida: estado_d = StAndando;
      StChegou: estado_d = StChegou;
      default:  estado_d = StAndando;
    endcase
  end

  always_ff @(posedge c4) begin
    if (reset) begin
      estado_q <= StAndando;
      acao_q   <= AcaoParado;
      x_q      <= CW'(X0);
      y_q      <= CW'(Y0);
      passos_q <= 8'd0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      acao_q   <= bus.acao;
      x_q      <= x_d;
      y_q      <= y_d;
      passos_q <= passos_d;
      erro_q   <= erro_d;
    end
  end

  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.passos = passos_q;
  assign bus.erro   = erro_q;
  assign bus.bateu  = (estado_q == StBatida);
  assign bus.chegou = (estado_q == StChegou);

endmodule

// File: tb/tb_posicao.sv
// Scoreboard bench for posicao: stimulus tasks update a grid-walk model and queue the
// expected outputs with the cycle they are due; a monitor on the falling edge compares.
module tb_posicao;
  import posicao_pkg::*;

  localparam int unsigned LARG   = 8;
  localparam int unsigned ALT    = 8;
  localparam int unsigned X0     = 0;
  localparam int unsigned Y0     = 0;
  localparam int unsigned MaxDim = (LARG > ALT) ? LARG : ALT;
  localparam int unsigned CW     = ($clog2(MaxDim) > 1) ? $clog2(MaxDim) : 1;

  logic c4 = 1'b0;
  logic reset = 1'b1;

  posicao_if #(.CW(CW)) bus ();

  posicao #(
    .LARG (LARG),
    .ALT  (ALT),
    .X0   (X0),
    .Y0   (Y0)
  ) dut (
    .c4    (c4),
    .reset (reset),
    .bus   (bus)
  );

  always #5 c4 = ~c4;

  typedef struct {
    int    due;
    int    x;
    int    y;
    int    passos;
    bit    bateu;
    bit    erro;
    bit    chegou;
    string tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // Model: position, executed moves, arrived flag, target.
  int mx, my, mp, tx, ty;
  bit marr;

  always @(posedge c4) cyc <= cyc + 1;

  always @(negedge c4) begin
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: check due at cycle %0d not reached (now %0d)", e.tag, e.due, cyc);
    end
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      n_tests++;
      if (int'(bus.x) != e.x || int'(bus.y) != e.y || int'(bus.passos) != e.passos ||
          bus.bateu != e.bateu || bus.erro != e.erro || bus.chegou != e.chegou) begin
        n_fail++;
        $display("FAIL %s @%0d: got x=%0d y=%0d passos=%0d bateu=%b erro=%b chegou=%b, want x=%0d y=%0d passos=%0d bateu=%b erro=%b chegou=%b",
                 e.tag, cyc, bus.x, bus.y, bus.passos, bus.bateu, bus.erro, bus.chegou,
                 e.x, e.y, e.passos, e.bateu, e.erro, e.chegou);
      end
    end
  end

  task automatic push(input int due, input bit b, input bit e, input string tag);
    exp_t t;
    t.due = due; t.x = mx; t.y = my; t.passos = mp;
    t.bateu = b; t.erro = e; t.chegou = marr; t.tag = tag;
    q.push_back(t);
  endtask

  // Grid rules applied to one request on the model.
  task automatic model_apply(input logic [2:0] code, output bit eb, output bit ee);
    int nx, ny;
    eb = 1'b0;
    ee = 1'b0;
    if (!marr) begin
      if (code > 3'd4) begin
        ee = 1'b1;
      end else if (code != 3'd0) begin
        nx = mx;
        ny = my;
        case (code)
          3'd1:    ny = my + 1;
          3'd2:    nx = mx - 1;
          3'd3:    nx = mx + 1;
          default: ny = my - 1;
        endcase
        if (nx < 0 || nx >= int'(LARG) || ny < 0 || ny >= int'(ALT)) begin
`ifdef POSICAO_TORUS_EN
          mx = (nx + int'(LARG)) % int'(LARG);
          my = (ny + int'(ALT)) % int'(ALT);
          mp = (mp < 255) ? mp + 1 : 255;
`else
          eb = 1'b1;
`endif
        end else begin
          mx = nx;
          my = ny;
          mp = (mp < 255) ? mp + 1 : 255;
        end
      end
    end
  endtask

  task automatic pulse(input logic [2:0] code, input int len, input string tag);
    int cur;
    bit eb, ee;
    @(posedge c4); #1;
    bus.acao = code;
    cur = cyc;
    model_apply(code, eb, ee);
    push(cur + 1, eb, ee, tag);
    if (mx == tx && my == ty) marr = 1'b1;
    push(cur + 2, 1'b0, 1'b0, tag);
    repeat (len) @(posedge c4);
    #1;
    bus.acao = 3'd0;
    repeat (2) @(posedge c4);
  endtask

  task automatic set_target(input int ax, input int ay, input string tag);
    int cur;
    @(posedge c4); #1;
    bus.alvo_x = ax[CW-1:0];
    bus.alvo_y = ay[CW-1:0];
    cur = cyc;
    tx = ax;
    ty = ay;
    if (mx == tx && my == ty) marr = 1'b1;
    push(cur + 2, 1'b0, 1'b0, tag);
    repeat (2) @(posedge c4);
  endtask

  task automatic do_reset(input bit with_n, input string tag);
    int cur;
    @(posedge c4); #1;
    reset = 1'b1;
    bus.acao = with_n ? 3'd1 : 3'd0;
    cur = cyc;
    mx = int'(X0); my = int'(Y0); mp = 0; marr = 1'b0;
    push(cur + 1, 1'b0, 1'b0, tag);
    @(posedge c4); #1;
    reset = 1'b0;
    bus.acao = 3'd0;
    if (mx == tx && my == ty) marr = 1'b1;
    push(cur + 3, 1'b0, 1'b0, tag);
    repeat (3) @(posedge c4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur, r;
    bit eb, ee;
    bus.acao = 3'd0;
    bus.alvo_x = 3'd7;
    bus.alvo_y = 3'd7;
    tx = 7; ty = 7;
    mx = 0; my = 0; mp = 0; marr = 1'b0;
    repeat (3) @(posedge c4);

    do_reset(1'b0, "reset_state");
    pulse(3'd1, 5, "n_held_once");
    do_reset(1'b0, "reset_a");
    pulse(3'd2, 1, "o_at_edge");
    pulse(3'd6, 1, "invalid_110");
    pulse(3'd7, 3, "invalid_111");

    do_reset(1'b0, "reset_b");
    set_target(2, 0, "target_2_0");
    pulse(3'd3, 1, "l_first");
    pulse(3'd3, 1, "l_arrive");
    pulse(3'd3, 1, "l_after_arrive");
    pulse(3'd6, 1, "invalid_in_chegou");
    do_reset(1'b1, "reset_in_chegou_with_n");

    set_target(0, 0, "target_start");
    do_reset(1'b0, "start_eq_target");
    set_target(7, 7, "target_7_7");
    do_reset(1'b0, "reset_c");

    // Refused move, then reset with a pending N while bateu is high.
    @(posedge c4); #1;
    bus.acao = 3'd2;
    cur = cyc;
    model_apply(3'd2, eb, ee);
    push(cur + 1, eb, ee, "o_before_reset");
    do_reset(1'b1, "reset_in_batida_with_n");

    for (int i = 0; i < 300; i++) pulse((i % 2 == 0) ? 3'd1 : 3'd4, 1, "saturate");

    do_reset(1'b0, "reset_rand");
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) do_reset(1'($urandom_range(0, 1)), "rand_reset");
      else if (r < 12) set_target($urandom_range(0, 7), $urandom_range(0, 7), "rand_target");
      else pulse(3'($urandom_range(1, 7)), $urandom_range(1, 3), "rand_pulse");
    end

    repeat (5) @(posedge c4);
    @(negedge c4); #1;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks left unverified, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/posicao.md
POSICAO -- requirements
Module: posicao

Interface
REQ-001 The block SHALL have parameter LARG, default 8, meaning grid width in cells (>=2).
REQ-002 The block SHALL have parameter ALT, default 8, meaning grid height in cells (>=2).
REQ-003 The block SHALL have parameters X0 and Y0, default 0 and 0, meaning the start cell after reset.
REQ-004 The block SHALL have localparam CW = max(1, clog2(max(LARG,ALT))), meaning the coordinate width.
REQ-005 The block SHALL have port c4 (input, 1): the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset (input, 1): synchronous, active-high reset.
REQ-007 The block SHALL have port acao (input, 3): action code 000 parado, 001 N, 010 O, 011 L, 100 S; 101-111 invalid.
REQ-008 The block SHALL have ports alvo_x and alvo_y (input, CW each): target cell, sampled every cycle.
REQ-009 The block SHALL have ports x and y (output, CW each): current registered position.
REQ-010 The block SHALL have port bateu (output, 1): one-cycle pulse when a move is refused at the grid edge.
REQ-011 The block SHALL have port chegou (output, 1): level, high while in state CHEGOU.
REQ-012 The block SHALL have port passos (output, 8): count of executed moves.
REQ-013 The block SHALL have port erro (output, 1): one-cycle pulse on an invalid acao pulse.

Function
REQ-014 The block SHALL detect a move request only on a cycle where acao != 000 and the registered previous acao == 000; a held code yields exactly one request.
REQ-015 The block SHALL apply moves as follows: N: y+1, S: y-1, L: x+1, O: x-1.
REQ-016 The block SHALL make the new x/y visible on the cycle after the request (latency 1).
REQ-017 The block SHALL implement FSM states: ANDANDO, BATIDA and CHEGOU.
- ANDANDO -> BATIDA on a refused move.
- BATIDA -> ANDANDO after exactly 1 cycle.
- ANDANDO -> CHEGOU when registered x,y equal alvo_x,alvo_y.
- CHEGOU is left only by reset.
REQ-018 While in BATIDA, the block SHALL assert bateu and SHALL ignore any new request.
REQ-019 While in CHEGOU, the block SHALL ignore requests: x, y and passos frozen, no bateu, no erro.
REQ-020 On an invalid code, the block SHALL pulse erro for one cycle and leave position and passos unchanged.
REQ-021 The block SHALL increment passos by 1 per executed move, saturating at 255; refused moves do not count.
REQ-022 If the start cell equals the target, the block SHALL enter CHEGOU on the first cycle after reset release.
REQ-023 If an out-of-range target is given (alvo_x>=LARG or alvo_y>=ALT), the block SHALL never assert chegou.

Reset
REQ-024 While reset is high, the block SHALL hold x=X0, y=Y0, passos=0, bateu=0, erro=0, chegou=0, state=ANDANDO, previous acao=000.
REQ-025 Reset SHALL override any request in the same cycle, including during BATIDA or CHEGOU.

Configuration
REQ-026 When macro POSICAO_TORUS_EN is defined, the block SHALL wrap edge moves: x LARG-1 -> 0 on L, 0 -> LARG-1 on O, and likewise y with ALT. Such moves execute, count in passos, and never assert bateu or enter BATIDA.
REQ-027 When POSICAO_TORUS_EN is undefined, the block SHALL refuse edge moves per REQ-017/REQ-018.

Structure
REQ-028 Package posicao_pkg SHALL hold the acao codes, the orientation codes (Norte 001, Oeste 010, Leste 011, Sul 100) and the FSM state enum.
REQ-029 Next-position computation SHALL be a combinational sub-module prox_pos with inputs x, y, acao and outputs nx, ny, fora_limite.

Verification
All scenarios use LARG=ALT=8, X0=Y0=0, alvo=(7,7) unless stated.
REQ-030 acao=001 held 5 cycles then 000 -> y=1 one cycle after the request, no further change, passos=1.
REQ-031 From (0,0), pulse acao=010 (O) -> x stays 0, bateu high exactly 1 cycle, passos=0. With POSICAO_TORUS_EN: x=7, bateu=0, passos=1.
REQ-032 alvo=(2,0); pulse L, 000, L -> x=2, chegou=1; a further L pulse leaves x=2 and passos=2.
REQ-033 Pulse acao=110 -> erro pulses 1 cycle; x, y and passos unchanged.
REQ-034 Assert reset while in CHEGOU or BATIDA, together with a pending N pulse -> next cycle x=0, y=0, passos=0, chegou=0, no move applied.
REQ-035 300 alternating N/S pulses -> passos saturates at 255, y toggles between 0 and 1.
